imem_boot_loader: RTL and testbench

- Writer side of the instruction-memory interface that the pipelined MIPS core reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory's write port at consecutive word addresses, holding the core in reset until the image is loaded and verified.
- Sits between the host byte source and the mem_inst write port; drives the core's rst.

---
 rtl/imem_boot_loader.sv | 129 ++++++++++++
 tb/tb_imem_boot_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed little-endian byte stream, writes 32-bit words into
// instruction memory, and releases the core from reset once the image checksum matches.
module imem_boot_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   output logic              core_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CAP = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_e;

   state_e            state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        csum_q, csum_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W:0]   wl_q, wl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [15:0]       n_new;
   logic              accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
         word_q  <= '0;
         wl_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         word_q  <= word_d;
         wl_q    <= wl_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Ready depends only on the registered state so the source never sees a combinational loop.
   assign in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
   assign accept   = in_valid && in_ready;
   assign n_new    = {in_byte, n_q[7:0]};

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      word_d  = word_q;
      wl_d    = wl_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_HDR0;
               wl_d    = '0;
               idx_d   = '0;
               csum_d  = '0;
            end
         end
         S_HDR0: begin
            if (accept) begin
               n_d[7:0] = in_byte;
               state_d  = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept) begin
               n_d[15:8] = in_byte;
               state_d   = (n_new == 16'd0 || 32'(n_new) > CAP) ? S_ERROR : S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d[{idx_q, 3'b000} +: 8] = in_byte;
               csum_d = csum_q ^ in_byte;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  // Latch the write port here so it holds steady outside the write cycle.
                  addr_d  = wl_q[ADDR_W-1:0];
                  data_d  = word_d;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            wl_d    = wl_q + 1'b1;
            state_d = (32'(wl_q) + 32'd1 == 32'(n_q)) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (accept) state_d = (in_byte == csum_q) ? S_DONE : S_ERROR;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_addr     = addr_q;
   assign mem_data     = data_q;
   assign mem_wren     = (state_q == S_WRITE);
   assign done         = (state_q == S_DONE);
   assign err          = (state_q == S_ERROR);
   assign core_rst     = (state_q != S_DONE);
   assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: frames are modelled as byte lists with expected writes queued up front;
// a negedge monitor pops and checks every mem_wren pulse.
module tb_imem_boot_loader;
   localparam int AW = 10;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [7:0]    in_byte = 8'h00;
   logic          in_ready, mem_wren, core_rst, done, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic [AW:0]   words_loaded;

   imem_boot_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
      .core_rst(core_rst), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int            n_pass = 0, n_total = 0;
   logic [AW-1:0] exp_a[$];
   logic [31:0]   exp_d[$];
   logic [7:0]    fb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (mem_wren === 1'b1) begin
         if (exp_a.size() == 0) chk("spurious_wren", 64'd1, 64'd0);
         else begin
            chk("wr_addr", 64'(mem_addr), 64'(exp_a[0]));
            chk("wr_data", 64'(mem_data), 64'(exp_d[0]));
            chk("ready_in_write", 64'(in_ready), 64'd0);
            void'(exp_a.pop_front());
            void'(exp_d.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic check_reset();
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_data", 64'(mem_data), 64'd0);
      chk("rst_mem_wren", 64'(mem_wren), 64'd0);
      chk("rst_core_rst", 64'(core_rst), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_words", 64'(words_loaded), 64'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      in_byte  = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 50) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_byte = 8'($urandom);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference: frame bytes and the writes they must produce, straight from the frame format.
   task automatic build(input logic [15:0] n, input logic [31:0] w[$], input bit bad,
                        input bit push_exp);
      logic [7:0]  cs = 8'h00;
      logic [31:0] wi;
      fb.delete();
      fb.push_back(n[7:0]);
      fb.push_back(n[15:8]);
      if (n != 16'd0 && n <= 16'(1 << AW)) begin
         for (int i = 0; i < int'(n); i++) begin
            wi = w[i];
            for (int k = 0; k < 4; k++) begin
               fb.push_back(wi[8*k +: 8]);
               cs ^= wi[8*k +: 8];
            end
            if (push_exp) begin
               exp_a.push_back(AW'(i));
               exp_d.push_back(wi);
            end
         end
         fb.push_back(bad ? (cs ^ 8'h01) : cs);
      end
   endtask

   task automatic load(input logic [15:0] n, input logic [31:0] w[$], input bit bad,
                       input int maxgap);
      bit hdr_ok = (n != 16'd0 && n <= 16'(1 << AW));
      int t = 0;
      build(n, w, bad, 1'b1);
      pulse_start();
      foreach (fb[i]) send_byte(fb[i], $urandom_range(0, maxgap));
      while (!(done || err) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("end_timeout", 64'(t < 100), 64'd1);
      chk("end_done", 64'(done), 64'(hdr_ok && !bad));
      chk("end_err", 64'(err), 64'(!hdr_ok || bad));
      chk("end_core_rst", 64'(core_rst), 64'(!(hdr_ok && !bad)));
      chk("end_words", 64'(words_loaded), hdr_ok ? 64'(n) : 64'd0);
      chk("writes_left", 64'(exp_a.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] t1[$];
      logic [31:0] big[$];
      logic [31:0] rw[$];
      logic [15:0] rn;
      t1 = '{32'h12345678, 32'hDEADBEEF};

      do_reset();
      check_reset();
      load(16'd2, t1, 1'b0, 0);            // test 1
      load(16'd2, t1, 1'b0, 3);            // test 2 as reload from DONE with gaps

      do_reset();
      load(16'd0, t1, 1'b0, 1);            // test 3
      pulse_start();
      repeat (5) @(negedge clk);
      chk("err_sticky", 64'(err), 64'd1);
      chk("err_core_rst", 64'(core_rst), 64'd1);
      chk("err_ready", 64'(in_ready), 64'd0);

      do_reset();
      load(16'd1025, t1, 1'b0, 0);         // test 4a
      do_reset();
      for (int i = 0; i < 1024; i++) big.push_back(32'(i));
      load(16'd1024, big, 1'b0, 0);        // test 4b

      do_reset();
      load(16'd2, t1, 1'b1, 1);            // test 5

      do_reset();                          // test 6
      build(16'd2, t1, 1'b0, 1'b0);
      exp_a.push_back('0);
      exp_d.push_back(32'h12345678);
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(fb[i], 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_reset();
      chk("mid_rst_writes", 64'(exp_a.size()), 64'd0);
      load(16'd2, t1, 1'b0, 0);

      for (int r = 0; r < 6; r++) begin    // randomized frames
         rw.delete();
         rn = 16'($urandom_range(1, 12));
         for (int i = 0; i < int'(rn); i++) rw.push_back($urandom);
         do_reset();
         load(rn, rw, ($urandom_range(0, 3) == 0), 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
